fft_frame_sequencer: RTL and testbench

//  Front/back-end controller for the 64-point parallel FFT core. Accepts one complex

---
 rtl/fft_frame_sequencer_pkg.sv | 36 +++
 rtl/fft_frame_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Package : fft_seq_pkg
// Brief   : Shared types, frame constants and the bit-reversal helper for the
//           64-point FFT frame sequencer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package fft_seq_pkg;

  localparam int N_POINTS = 64;
  localparam int LOG2_N   = 6;
  localparam int D_WIDTH  = 16;

  // Index of the final sample in a frame (load and drain counters)
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  // Mirror the index bits: bit i moves to bit LOG2_N-1-i
  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] k);
    logic [LOG2_N-1:0] r;
    for (int i = 0; i < LOG2_N; i++) begin
      r[LOG2_N-1-i] = k[i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
//------------------------------------------------------------------------------
// Module : fft_frame_sequencer
// Brief  : Loads one complex sample per handshake into bit-reversed slots,
//          starts the parallel FFT core, captures its result frame and
//          streams it back out in natural order.
// Config : FFT_SEQ_TIMEOUT_EN - adds a WAIT-state watchdog (TIMEOUT_CYCLES)
//          that pulses err_timeout and abandons the frame.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  // sample input stream
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_re,
  input  logic [D_WIDTH-1:0] in_im,
  // FFT core interface
  output logic [D_WIDTH-1:0] fft_re [N_POINTS],
  output logic [D_WIDTH-1:0] fft_im [N_POINTS],
  output logic               fft_start,
  input  logic               fft_done,
  input  logic [D_WIDTH-1:0] res_re [N_POINTS],
  input  logic [D_WIDTH-1:0] res_im [N_POINTS],
  // result output stream
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_re,
  output logic [D_WIDTH-1:0] out_im,
  output logic               out_last,
  // status
  output logic               busy,
  output logic [7:0]         frame_cnt,
  output logic               err_timeout
);

  // A watchdog of zero cycles cannot express a meaningful limit
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  seq_state_t         state;
  seq_state_t         next_state;
  logic [LOG2_N-1:0]  ld_cnt;
  logic [LOG2_N-1:0]  dr_cnt;
  logic [D_WIDTH-1:0] rbuf_re [N_POINTS];
  logic [D_WIDTH-1:0] rbuf_im [N_POINTS];
  logic               in_fire;
  logic               out_fire;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_re    = rbuf_re[dr_cnt];
  assign out_im    = rbuf_im[dr_cnt];
  assign out_last  = out_valid && (dr_cnt == LAST_IDX);
  assign busy      = (state != LOAD) || (ld_cnt != '0);

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            timeout_pulse;

  // Watchdog: counts WAIT cycles, registers a one-cycle pulse on expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt        <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;
      if (state == WAIT && !fft_done && !timeout_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign err_timeout = timeout_pulse;
`else
  assign err_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; fft_done only matters while waiting on the core
  always_comb begin
    next_state = state;
`ifdef FFT_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      LOAD:  if (in_fire && ld_cnt == LAST_IDX) next_state = START;
      START: next_state = WAIT;
      WAIT: begin
        if (fft_done) begin
          next_state = DRAIN;
`ifdef FFT_SEQ_TIMEOUT_EN
        end else if (to_cnt == TO_LIMIT) begin
          next_state  = LOAD;
          timeout_hit = 1'b1;
`endif
        end
      end
      DRAIN: if (out_fire && dr_cnt == LAST_IDX) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  // Datapath: frame buffers, counters, start pulse and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_POINTS; i++) begin
        fft_re[i]  <= '0;
        fft_im[i]  <= '0;
        rbuf_re[i] <= '0;
        rbuf_im[i] <= '0;
      end
      ld_cnt    <= '0;
      dr_cnt    <= '0;
      frame_cnt <= '0;
      fft_start <= 1'b0;
    end else begin
      fft_start <= (state == LOAD) && (next_state == START);
      if (in_fire) begin
        fft_re[bitrev(ld_cnt)] <= in_re;
        fft_im[bitrev(ld_cnt)] <= in_im;
        ld_cnt                 <= ld_cnt + 1'b1;
      end
      if (state == WAIT && fft_done) begin
        for (int i = 0; i < N_POINTS; i++) begin
          rbuf_re[i] <= res_re[i];
          rbuf_im[i] <= res_im[i];
        end
      end
      if (out_fire) begin
        dr_cnt <= dr_cnt + 1'b1;
        if (dr_cnt == LAST_IDX) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_fft_frame_sequencer
// Brief  : Self-checking bench for fft_frame_sequencer with a stub FFT core.
//          Watchdog checks run when FFT_SEQ_TIMEOUT_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fft_frame_sequencer;
  import fft_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [D_WIDTH-1:0] in_re, in_im;
  logic [D_WIDTH-1:0] fft_re [N_POINTS];
  logic [D_WIDTH-1:0] fft_im [N_POINTS];
  logic               fft_start;
  logic               fft_done;
  logic [D_WIDTH-1:0] res_re [N_POINTS];
  logic [D_WIDTH-1:0] res_im [N_POINTS];
  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] out_re, out_im;
  logic               out_last;
  logic               busy;
  logic [7:0]         frame_cnt;
  logic               err_timeout;

  always #5 clk = ~clk;

  fft_frame_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .fft_re(fft_re), .fft_im(fft_im), .fft_start(fft_start), .fft_done(fft_done),
    .res_re(res_re), .res_im(res_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
  );

  int tests = 0;
  int fails = 0;
  int exp_frames = 0;

  logic [D_WIDTH-1:0] src_re [N_POINTS];
  logic [D_WIDTH-1:0] src_im [N_POINTS];
  logic [D_WIDTH-1:0] exp_re [N_POINTS];
  logic [D_WIDTH-1:0] exp_im [N_POINTS];

  typedef struct {
    int                 slot;
    logic [D_WIDTH-1:0] re;
    logic [D_WIDTH-1:0] im;
  } vec_t;
  vec_t tv [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference bit reversal by arithmetic on powers of two
  function automatic int rev_idx(input int k);
    int r = 0;
    for (int b = 0; b < LOG2_N; b++) begin
      if (((k / (1 << b)) % 2) == 1) r = r + (1 << (LOG2_N - 1 - b));
    end
    return r;
  endfunction

  task automatic fill_src_ramp();
    for (int k = 0; k < N_POINTS; k++) begin
      src_re[k] = D_WIDTH'(k);
      src_im[k] = D_WIDTH'(-k);
    end
  endtask

  task automatic fill_src_rand();
    for (int k = 0; k < N_POINTS; k++) begin
      src_re[k] = D_WIDTH'($urandom);
      src_im[k] = D_WIDTH'($urandom);
    end
  endtask

  // Feed one frame; optionally with valid gaps and a stray fft_done at a cycle
  task automatic load_frame(input bit gaps, input int stray_done_cyc);
    int acc = 0;
    int cyc = 0;
    bit early = 1'b0;
    while (acc < N_POINTS && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (fft_start) early = 1'b1;
      fft_done = (cyc == stray_done_cyc);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_re    = src_re[acc];
      in_im    = src_im[acc];
      if (in_valid && in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    fft_done = 1'b0;
    chk("load_accept_count", acc, N_POINTS);
    chk("no_early_start", early, 0);
    chk("start_pulse", fft_start, 1);
    chk("ready_low_in_start", in_ready, 0);
    for (int j = 0; j < N_POINTS; j++) begin
      chk("frame_re", fft_re[j], src_re[rev_idx(j)]);
      chk("frame_im", fft_im[j], src_im[rev_idx(j)]);
    end
  endtask

  // Called in the START cycle: stub core answers after `delay` WAIT cycles
  task automatic run_core(input int delay, input bit stray_in_start);
    bit early_valid = 1'b0;
    fft_done = stray_in_start;
    @(negedge clk);
    fft_done = 1'b0;
    chk("start_single_cycle", fft_start, 0);
    for (int c = 0; c < delay; c++) begin
      if (out_valid) early_valid = 1'b1;
      @(negedge clk);
    end
    chk("no_drain_before_done", early_valid, 0);
    for (int i = 0; i < N_POINTS; i++) begin
      res_re[i] = exp_re[i];
      res_im[i] = exp_im[i];
    end
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    // Scramble the core outputs: the drain must use the captured copy
    for (int i = 0; i < N_POINTS; i++) begin
      res_re[i] = D_WIDTH'($urandom);
      res_im[i] = D_WIDTH'($urandom);
    end
    chk("done_to_valid", out_valid, 1);
  endtask

  // Drain one result frame, checking order, stall stability and out_last
  task automatic drain(input bit rand_ready);
    int idx = 0;
    int cyc = 0;
    int stab_err = 0;
    int last_err = 0;
    bit stalled = 1'b0;
    int hs_at_last = 0;
    logic [D_WIDTH-1:0] prev_re, prev_im;
    while (idx < N_POINTS && cyc < 2000) begin
      if (stalled && (out_re !== prev_re || out_im !== prev_im)) stab_err++;
      if (out_valid && (out_last !== (idx == N_POINTS - 1))) last_err++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        chk("drain_re", out_re, exp_re[idx]);
        chk("drain_im", out_im, exp_im[idx]);
        if (out_last) hs_at_last++;
        idx++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        prev_re = out_re;
        prev_im = out_im;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    exp_frames++;
    chk("drain_handshakes", idx, N_POINTS);
    chk("stall_stability", stab_err, 0);
    chk("out_last_position", last_err, 0);
    chk("out_last_once", hs_at_last, 1);
    chk("post_drain_valid", out_valid, 0);
    chk("post_drain_ready", in_ready, 1);
    chk("frame_cnt", frame_cnt, exp_frames % 256);
  endtask

  task automatic set_exp_rand();
    for (int i = 0; i < N_POINTS; i++) begin
      exp_re[i] = D_WIDTH'($urandom);
      exp_im[i] = D_WIDTH'($urandom);
    end
  endtask

  task automatic check_table();
    for (int t = 0; t < 6; t++) begin
      chk("table_re", fft_re[tv[t].slot], tv[t].re);
      chk("table_im", fft_im[tv[t].slot], tv[t].im);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_fft_start"}, fft_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_fft_re32"}, fft_re[32], 0);
    chk({tag, "_fft_im32"}, fft_im[32], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    tv[0] = '{slot: 1,  re: 16'd32, im: 16'hFFE0};
    tv[1] = '{slot: 32, re: 16'd1,  im: 16'hFFFF};
    tv[2] = '{slot: 48, re: 16'd3,  im: 16'hFFFD};
    tv[3] = '{slot: 0,  re: 16'd0,  im: 16'h0000};
    tv[4] = '{slot: 63, re: 16'd63, im: 16'hFFC1};
    tv[5] = '{slot: 2,  re: 16'd16, im: 16'hFFF0};

    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
    fft_done = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < N_POINTS; i++) begin
      res_re[i] = '0;
      res_im[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Ramp frame, no stalls; stub core returns i+100
    fill_src_ramp();
    load_frame(1'b0, -1);
    check_table();
    chk("busy_in_start", busy, 1);
    for (int i = 0; i < N_POINTS; i++) begin
      exp_re[i] = D_WIDTH'(i + 100);
      exp_im[i] = D_WIDTH'(i * 3);
    end
    run_core(5, 1'b0);
    drain(1'b0);

    // Stray fft_done in LOAD and START, random out_ready while draining
    fill_src_rand();
    set_exp_rand();
    load_frame(1'b1, 10);
    run_core(4, 1'b1);
    drain(1'b1);

    // Randomized frames against the reference model
    for (int f = 0; f < 4; f++) begin
      fill_src_rand();
      set_exp_rand();
      load_frame(1'b1, -1);
      run_core($urandom_range(1, 8), 1'b0);
      drain(1'b1);
    end

    // Reset in the middle of a frame
    fill_src_ramp();
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1;
      in_re = src_re[k];
      in_im = src_im[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("partial_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_frames = 0;
    check_reset_state("midreset");
    load_frame(1'b0, -1);
    check_table();
    set_exp_rand();
    run_core(2, 1'b0);
    drain(1'b0);

`ifdef FFT_SEQ_TIMEOUT_EN
    // Withheld fft_done: watchdog fires 16 cycles after WAIT entry
    begin
      bit early_to = 1'b0;
      fill_src_rand();
      load_frame(1'b1, -1);
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (err_timeout) early_to = 1'b1;
      end
      chk("timeout_not_early", early_to, 0);
      @(negedge clk);
      chk("timeout_pulse", err_timeout, 1);
      chk("timeout_back_to_load", in_ready, 1);
      chk("timeout_no_drain", out_valid, 0);
      chk("timeout_frame_cnt", frame_cnt, exp_frames % 256);
      @(negedge clk);
      chk("timeout_single_pulse", err_timeout, 0);
    end

    // fft_done on the final WAIT cycle beats the watchdog
    fill_src_rand();
    set_exp_rand();
    load_frame(1'b0, -1);
    repeat (16) @(negedge clk);
    for (int i = 0; i < N_POINTS; i++) begin
      res_re[i] = exp_re[i];
      res_im[i] = exp_im[i];
    end
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    chk("done_wins_no_timeout", err_timeout, 0);
    chk("done_wins_drain", out_valid, 1);
    drain(1'b0);
`else
    chk("err_timeout_tied", err_timeout, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
